// File: rtl/io_bridge_pkg.sv
// Shared defaults and FIFO occupancy encoding for the host/processor IO bridge.
// No logic; imported by io_fifo and io_bridge.
package io_bridge_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO: a push at edge N is visible on pop_data after edge N.
// push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module io_fifo
    import io_bridge_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WORD_W = WORD_W_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    fifo_state_t       state;
    fifo_state_t       state_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (state != FIFO_EMPTY);
    assign do_push = push && ((state != FIFO_FULL) || do_pop);

    always_comb begin
        count_nxt = count;
        state_nxt = state;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        // A single push or pop moves count by one, so the state can only step to a neighbour.
        if (count_nxt == '0) begin
            state_nxt = FIFO_EMPTY;
        end else if (count_nxt == CNT_W'(DEPTH)) begin
            state_nxt = FIFO_FULL;
        end else begin
            state_nxt = FIFO_PARTIAL;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= FIFO_EMPTY;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // Storage is left uncleared; consumers mask the head while empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (state == FIFO_EMPTY);
    assign full     = (state == FIFO_FULL);

endmodule

// File: rtl/io_bridge.sv
// Host <-> processor bridge: one FWFT FIFO per direction, zero-latency head, outputs zero when empty.
// Host input is backpressured by host_in_ready; processor writes into a full, non-draining FIFO are dropped and flagged.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [WORD_W-1:0] cpu_in,
    output logic              cpu_in_avail,
    input  logic              cpu_in_ack,
    input  logic [WORD_W-1:0] cpu_out,
    input  logic              cpu_out_write,
    output logic [WORD_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] in_head;
    logic [CNT_W-1:0]  in_count;
    logic              in_full;
    logic              in_empty;
    logic              in_push;
    logic              in_pop;

    logic [WORD_W-1:0] out_head;
    logic [CNT_W-1:0]  out_count;
    logic              out_full;
    logic              out_empty;
    logic              out_push;
    logic              out_pop;
    logic              overflow_set;
    logic              unused_status;

    // Ready depends only on registered occupancy, never on cpu_in_ack.
    assign host_in_ready = (in_count != CNT_W'(DEPTH));
    assign in_push       = host_in_valid && host_in_ready;
    assign in_pop        = cpu_in_ack && !in_empty;
    assign cpu_in_avail  = !in_empty;
    assign cpu_in        = in_empty ? '0 : in_head;

    io_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_in_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_push),
        .push_data (host_in_data),
        .pop       (in_pop),
        .pop_data  (in_head),
        .count     (in_count),
        .full      (in_full),
        .empty     (in_empty)
    );

    // A full output FIFO still takes a write when the host drains a word in the same cycle.
    assign out_pop        = host_out_ready && !out_empty;
    assign out_push       = cpu_out_write && (!out_full || out_pop);
    assign overflow_set   = cpu_out_write && out_full && !out_pop;
    assign host_out_valid = !out_empty;
    assign host_out_data  = out_empty ? '0 : out_head;

    io_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_out_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (out_push),
        .push_data (cpu_out),
        .pop       (out_pop),
        .pop_data  (out_head),
        .count     (out_count),
        .full      (out_full),
        .empty     (out_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end
    end

    assign unused_status = ^{in_full, out_count};

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge; expected words queued at issue, compared by a monitor on handshake.
module tb_io_bridge;

    logic        clock;
    logic        reset_n;
    logic [15:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [15:0] cpu_in;
    logic        cpu_in_avail;
    logic        cpu_in_ack;
    logic [15:0] cpu_out;
    logic        cpu_out_write;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_cpu  [$];
    logic [15:0] exp_host [$];

    io_bridge #(.DEPTH(4), .WORD_W(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .cpu_in         (cpu_in),
        .cpu_in_avail   (cpu_in_avail),
        .cpu_in_ack     (cpu_in_ack),
        .cpu_out        (cpu_out),
        .cpu_out_write  (cpu_out_write),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_host_in_ready"},  32'(host_in_ready),  32'd1);
        check({tag, "_cpu_in_avail"},   32'(cpu_in_avail),   32'd0);
        check({tag, "_cpu_in"},         32'(cpu_in),         32'd0);
        check({tag, "_host_out_valid"}, 32'(host_out_valid), 32'd0);
        check({tag, "_host_out_data"},  32'(host_out_data),  32'd0);
        check({tag, "_overflow"},       32'(overflow),       32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_cpu.delete();
        exp_host.delete();
        tick();
        tick();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();
    endtask

    task automatic host_push(input logic [15:0] w, input bit expect_accept);
        host_in_valid = 1'b1;
        host_in_data  = w;
        if (expect_accept) exp_cpu.push_back(w);
        tick();
        host_in_valid = 1'b0;
        host_in_data  = 16'h0;
    endtask

    task automatic cpu_write(input logic [15:0] w, input bit expect_accept);
        cpu_out_write = 1'b1;
        cpu_out       = w;
        if (expect_accept) exp_host.push_back(w);
        tick();
        cpu_out_write = 1'b0;
        cpu_out       = 16'h0;
    endtask

    task automatic ack_cycles(input int n);
        cpu_in_ack = 1'b1;
        repeat (n) tick();
        cpu_in_ack = 1'b0;
    endtask

    task automatic drain_cycles(input int n);
        host_out_ready = 1'b1;
        repeat (n) tick();
        host_out_ready = 1'b0;
    endtask

    // Scoreboard monitor: samples on the falling edge, where inputs are stable.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge clock);
            if (reset_n && cpu_in_avail && cpu_in_ack) begin
                if (exp_cpu.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cpu_in_unexpected: got=%h expected=<none>", cpu_in);
                end else begin
                    w = exp_cpu.pop_front();
                    check("cpu_in_order", 32'(cpu_in), 32'(w));
                end
            end
            if (reset_n && host_out_valid && host_out_ready) begin
                if (exp_host.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL host_out_unexpected: got=%h expected=<none>", host_out_data);
                end else begin
                    w = exp_host.pop_front();
                    check("host_out_order", 32'(host_out_data), 32'(w));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        host_in_data   = 16'h0;
        host_in_valid  = 1'b0;
        cpu_in_ack     = 1'b0;
        cpu_out        = 16'h0;
        cpu_out_write  = 1'b0;
        host_out_ready = 1'b0;
        #3;
        do_reset();

        // Two words through the input path, FWFT head and masking after drain
        host_push(16'h0011, 1'b1);
        check("fwft_head", 32'(cpu_in), 32'h0011);
        check("fwft_avail", 32'(cpu_in_avail), 32'd1);
        host_push(16'h0022, 1'b1);
        ack_cycles(1);
        check("second_head", 32'(cpu_in), 32'h0022);
        ack_cycles(1);
        check("drained_avail", 32'(cpu_in_avail), 32'd0);
        check("drained_cpu_in", 32'(cpu_in), 32'd0);

        // Ack/ready on empty FIFOs must be ignored
        cpu_in_ack = 1'b1;
        host_out_ready = 1'b1;
        tick();
        cpu_in_ack = 1'b0;
        host_out_ready = 1'b0;
        check("empty_ack_avail", 32'(cpu_in_avail), 32'd0);
        check("empty_ready_valid", 32'(host_out_valid), 32'd0);

        // Fill input FIFO, refuse the fifth word
        for (int i = 0; i < 4; i++) host_push(16'hA000 + 16'(i), 1'b1);
        check("in_full_ready", 32'(host_in_ready), 32'd0);
        host_push(16'hA004, 1'b0);
        check("in_full_head", 32'(cpu_in), 32'hA000);
        ack_cycles(4);
        check("in_after_drain_avail", 32'(cpu_in_avail), 32'd0);
        check("in_after_drain_ready", 32'(host_in_ready), 32'd1);

        // Output overflow: fifth write dropped, flag sticky
        for (int i = 1; i <= 4; i++) cpu_write(16'(i), 1'b1);
        check("out_full_no_ovf", 32'(overflow), 32'd0);
        check("out_full_head", 32'(host_out_data), 32'h0001);
        cpu_write(16'h0005, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        drain_cycles(4);
        check("ovf_drained_valid", 32'(host_out_valid), 32'd0);
        check("ovf_drained_data", 32'(host_out_data), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full output FIFO with concurrent write and pop
        do_reset();
        for (int i = 1; i <= 4; i++) cpu_write(16'h0100 + 16'(i), 1'b1);
        cpu_out_write  = 1'b1;
        cpu_out        = 16'hBEEF;
        host_out_ready = 1'b1;
        exp_host.push_back(16'hBEEF);
        tick();
        cpu_out_write  = 1'b0;
        host_out_ready = 1'b0;
        check("full_rw_no_ovf", 32'(overflow), 32'd0);
        check("full_rw_count", 32'(dut.u_out_fifo.count), 32'd4);
        check("full_rw_head", 32'(host_out_data), 32'h0102);
        drain_cycles(4);
        check("full_rw_empty", 32'(host_out_valid), 32'd0);

        // Continuous push+pop on both paths across pointer wrap
        host_in_valid = 1'b1;
        host_in_data  = 16'd1;
        cpu_out_write = 1'b1;
        cpu_out       = 16'h0201;
        exp_cpu.push_back(16'd1);
        exp_host.push_back(16'h0201);
        tick();
        for (int k = 2; k <= 10; k++) begin
            host_in_data   = 16'(k);
            cpu_out        = 16'h0200 + 16'(k);
            cpu_in_ack     = 1'b1;
            host_out_ready = 1'b1;
            exp_cpu.push_back(16'(k));
            exp_host.push_back(16'h0200 + 16'(k));
            tick();
            check("stream_in_count", 32'(dut.u_in_fifo.count), 32'd1);
            check("stream_out_count", 32'(dut.u_out_fifo.count), 32'd1);
        end
        host_in_valid = 1'b0;
        cpu_out_write = 1'b0;
        tick();
        cpu_in_ack     = 1'b0;
        host_out_ready = 1'b0;
        check("stream_in_empty", 32'(cpu_in_avail), 32'd0);
        check("stream_out_empty", 32'(host_out_valid), 32'd0);

        // Asynchronous reset with three words buffered on each side
        for (int i = 0; i < 3; i++) begin
            host_push(16'h3300 + 16'(i), 1'b0);
            cpu_write(16'h4400 + 16'(i), 1'b0);
        end
        check("pre_reset_avail", 32'(cpu_in_avail), 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        exp_cpu.delete();
        exp_host.delete();
        tick();
        reset_n = 1'b1;
        tick();
        host_in_valid = 1'b1;
        host_in_data  = 16'h7777;
        cpu_out_write = 1'b1;
        cpu_out       = 16'h7777;
        exp_cpu.push_back(16'h7777);
        exp_host.push_back(16'h7777);
        tick();
        host_in_valid = 1'b0;
        cpu_out_write = 1'b0;
        check("post_reset_cpu_in", 32'(cpu_in), 32'h7777);
        check("post_reset_host_out", 32'(host_out_data), 32'h7777);
        cpu_in_ack     = 1'b1;
        host_out_ready = 1'b1;
        tick();
        cpu_in_ack     = 1'b0;
        host_out_ready = 1'b0;
        tick();

        check("sb_cpu_left", 32'(exp_cpu.size()), 32'd0);
        check("sb_host_left", 32'(exp_host.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter: DEPTH, 4, entries per FIFO; power of two, 2..16.
REQ-002 Parameter: WORD_W, 16, data width; matches processor in/out width.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 host_in_data  input  WORD_W  word offered by host toward processor.
REQ-006 host_in_valid  input  1  host_in_data valid this cycle.
REQ-007 host_in_ready  output  1  input FIFO can accept a word.
REQ-008 cpu_in  output  WORD_W  head of input FIFO; drives processor in port.
REQ-009 cpu_in_avail  output  1  input FIFO non-empty.
REQ-010 cpu_in_ack  input  1  processor consumed cpu_in this cycle.
REQ-011 cpu_out  input  WORD_W  processor out port value.
REQ-012 cpu_out_write  input  1  processor OutputWrite strobe.
REQ-013 host_out_data  output  WORD_W  head of output FIFO.
REQ-014 host_out_valid  output  1  output FIFO non-empty.
REQ-015 host_out_ready  input  1  host takes host_out_data this cycle.
REQ-016 overflow  output  1  sticky: processor write dropped.

Function
REQ-017 Input path SHALL push host_in_data when host_in_valid && host_in_ready at a rising edge.
REQ-018 host_in_ready SHALL equal (in_count != DEPTH), independent of cpu_in_ack (no combinational ready-to-ack path).
REQ-019 Input FIFO SHALL be first-word-fall-through: word pushed at edge N appears on cpu_in and cpu_in_avail=1 after edge N when FIFO was empty.
REQ-020 cpu_in SHALL be 0 whenever cpu_in_avail=0.
REQ-021 cpu_in_ack with cpu_in_avail=0 SHALL be ignored; no pointer or count change.
REQ-022 Simultaneous push and pop on input FIFO SHALL leave in_count unchanged, advance both pointers.
REQ-023 Output path SHALL push cpu_out when cpu_out_write at a rising edge, unless output FIFO full and no pop in same cycle.
REQ-024 Output FIFO full with cpu_out_write and host_out_ready both asserted SHALL accept the write and the pop; count stays DEPTH.
REQ-025 Output FIFO full, cpu_out_write=1, host_out_ready=0 SHALL drop the word and set overflow at that edge.
REQ-026 overflow SHALL remain 1 until reset_n asserted.
REQ-027 host_out_ready with host_out_valid=0 SHALL be ignored.
REQ-028 host_out_data SHALL be 0 whenever host_out_valid=0.
REQ-029 Read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; counts SHALL be clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-030 Order SHALL be strictly preserved in both directions; no word duplicated or reordered.
REQ-031 Per-FIFO state SHALL be EMPTY (count 0), PARTIAL, FULL (count DEPTH); transitions only via push/pop rules above, never skipping a state per edge.

Reset
REQ-032 reset_n low SHALL immediately clear pointers, counts, and overflow, independent of clock.
REQ-033 During and after reset: host_in_ready=1, cpu_in_avail=0, cpu_in=0, host_out_valid=0, host_out_data=0, overflow=0.
REQ-034 Reset mid-transfer SHALL discard all buffered words; first push after release is first word out.
REQ-035 Storage arrays need not be cleared; outputs are masked per REQ-020/REQ-028.

Structure
REQ-036 Package io_bridge_pkg SHALL hold WORD_W default, DEPTH default, and the FIFO state encoding (EMPTY/PARTIAL/FULL).
REQ-037 One sub-module io_fifo (push, pop, data in/out, count, full, empty) SHALL be instantiated twice: input path and output path.
REQ-038 Overflow flag and output-mask logic SHALL live in io_bridge, not io_fifo.

Verification
REQ-039 Reset, then push 16'h0011, 16'h0022 from host -> cpu_in=16'h0011, avail=1; ack once -> cpu_in=16'h0022; ack again -> avail=0, cpu_in=0.
REQ-040 Push 4 words 16'hA000..16'hA003 with no ack -> host_in_ready=0 after 4th edge; 5th valid word not accepted; acks return A000..A003 in order.
REQ-041 Five cpu_out_write pulses 16'h0001..16'h0005, host_out_ready=0 -> 16'h0005 dropped, overflow=1; drain yields 0001..0004; overflow stays 1.
REQ-042 Output FIFO full, cpu_out_write=16'hBEEF with host_out_ready=1 same cycle -> no overflow; count stays 4; BEEF emerges last.
REQ-043 Continuous push+pop for 10 cycles (values 1..10) across pointer wrap -> outputs 1..10 in order, count constant.
REQ-044 Assert reset_n low mid-clock with 3 words buffered each side -> outputs per REQ-033 immediately; next push 16'h7777 appears first.
